// File: rtl/pulse_width_meter.sv
// Measures the high time of an asynchronous pulse in enabled clock ticks and
// reports each saturating result over a valid/ready handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// ARM     | wait for synchronized input low so no partial pulse is measured
// IDLE    | input low, waiting for a rising edge
// MEASURE | pulse high, counting enabled ticks
// REPORT  | result presented, waiting for valid & ready
module pulse_width_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             tick_en,
    output logic [WIDTH-1:0] width_out,
    output logic             overflow,
    output logic             valid,
    input  logic             ready
);

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             sync;
    logic             sync_d;
    logic             rise;
    logic [WIDTH-1:0] cnt;
    logic             ovf;

    logic             load_cnt;
    logic             step_cnt;
    logic             capture;
    logic             accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            s1     <= sig_in;
            sync   <= s1;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARM: begin
                if (!sync) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (!sync) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (valid && ready) begin
                    state_nxt = ARM;
                end
            end
            default: state_nxt = ARM;
        endcase
    end

    always_comb begin
        load_cnt = 1'b0;
        step_cnt = 1'b0;
        capture  = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE:    load_cnt = rise;
            MEASURE: begin
                step_cnt = sync & tick_en;
                capture  = ~sync;
            end
            REPORT:  accept = valid & ready;
            default: ;
        endcase
    end

    // Counter saturates at MAX; the overflow flag records that a tick was lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= ZERO;
            ovf <= 1'b0;
        end else if (load_cnt) begin
            cnt <= tick_en ? ONE : ZERO;
            ovf <= 1'b0;
        end else if (step_cnt) begin
            if (cnt == MAX) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width_out <= ZERO;
            overflow  <= 1'b0;
            valid     <= 1'b0;
        end else if (capture) begin
            width_out <= cnt;
            overflow  <= ovf;
            valid     <= 1'b1;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter with a cycle-level reference model and
// per-cycle output comparison.
module tb_pulse_width_meter;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic         sig_in  = 1'b1;
    logic         tick_en = 1'b1;
    logic         ready   = 1'b1;
    logic [W-1:0] width_out;
    logic         overflow;
    logic         valid;

    int n_checks = 0;
    int n_pass   = 0;
    bit prescale = 1'b0;
    int cyc      = 0;
    int lat;

    pulse_width_meter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .tick_en   (tick_en),
        .width_out (width_out),
        .overflow  (overflow),
        .valid     (valid),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: the synchronized input is the raw input seen two edges
    // earlier; the width is the number of enabled ticks while that delayed
    // input is high, clipped at MAXV, with overflow when ticks exceed MAXV.
    typedef enum {M_ARM, M_IDLE, M_MEAS, M_REP} mphase_t;
    mphase_t ph        = M_ARM;
    bit      h0        = 1'b0;
    bit      h1        = 1'b0;
    bit      h2        = 1'b0;
    int      ticks     = 0;
    bit      exp_valid = 1'b0;
    int      exp_w     = 0;
    bit      exp_o     = 1'b0;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            ph = M_ARM; h0 = 0; h1 = 0; h2 = 0;
            ticks = 0; exp_valid = 0; exp_w = 0; exp_o = 0;
        end else begin
            case (ph)
                M_ARM:  if (!h1) ph = M_IDLE;
                M_IDLE: if (h1 && !h2) begin
                    ph = M_MEAS;
                    ticks = int'(tick_en);
                end
                M_MEAS: if (h1) begin
                    ticks += int'(tick_en);
                end else begin
                    exp_valid = 1;
                    exp_w = (ticks > MAXV) ? MAXV : ticks;
                    exp_o = (ticks > MAXV);
                    ph = M_REP;
                end
                M_REP:  if (ready) begin
                    exp_valid = 0;
                    ph = M_ARM;
                end
            endcase
            h2 = h1; h1 = h0; h0 = sig_in;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            check("rst_valid", valid, 0);
            check("rst_width", width_out, 0);
            check("rst_overflow", overflow, 0);
        end else begin
            check("valid", valid, exp_valid);
            if (exp_valid) begin
                check("width", width_out, exp_w);
                check("overflow", overflow, exp_o);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (prescale) tick_en = (cyc % 4 == 0);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        sig_in = 1'b1;
        cycles(n);
        sig_in = 1'b0;
    endtask

    // Returns number of edges after the pulse ended until valid is seen.
    task automatic wait_valid(output int l);
        l = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            l++;
            if (valid) break;
        end
        check("valid_timeout", valid, 1);
    endtask

    initial begin
        #1;
        reset_n = 1'b0;
        cycles(3);
        check("reset_width", width_out, 0);
        check("reset_overflow", overflow, 0);
        check("reset_valid", valid, 0);
        reset_n = 1'b1;
        cycles(20);
        check("no_valid_while_high_after_reset", valid, 0);
        sig_in = 1'b0;
        cycles(5);

        pulse(10);
        wait_valid(lat);
        check("basic_latency", lat, 3);
        check("basic_width", width_out, 10);
        check("basic_overflow", overflow, 0);
        cycles(1);
        check("basic_single_valid", valid, 0);
        cycles(4);

        prescale = 1'b1;
        cycles(1);
        pulse(40);
        wait_valid(lat);
        check("prescale_width", width_out, 10);
        check("prescale_overflow", overflow, 0);
        prescale = 1'b0;
        tick_en  = 1'b1;
        cycles(5);

        pulse(300);
        wait_valid(lat);
        check("sat_width", width_out, 255);
        check("sat_overflow", overflow, 1);
        cycles(4);
        pulse(5);
        wait_valid(lat);
        check("post_sat_width", width_out, 5);
        check("post_sat_overflow", overflow, 0);
        cycles(4);

        ready = 1'b0;
        pulse(7);
        wait_valid(lat);
        check("bp_width", width_out, 7);
        cycles(3);
        pulse(3);
        cycles(6);
        check("bp_valid_held", valid, 1);
        check("bp_width_held", width_out, 7);
        ready = 1'b1;
        cycles(1);
        check("bp_accepted", valid, 0);
        cycles(15);
        check("bp_dropped_pulse", valid, 0);

        sig_in = 1'b1;
        cycles(5);
        reset_n = 1'b0;
        #1;
        check("midrst_width", width_out, 0);
        check("midrst_valid", valid, 0);
        cycles(1);
        reset_n = 1'b1;
        cycles(5);
        sig_in = 1'b0;
        cycles(15);
        check("midrst_no_valid", valid, 0);
        pulse(6);
        wait_valid(lat);
        check("midrst_next_width", width_out, 6);
        check("midrst_next_overflow", overflow, 0);
        cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
